// File: rtl/snn_rate_encoder.sv
`timescale 1ns/1ps
// snn_rate_encoder: input stage of the tinysnn core.
// Collects N_CH 8-bit intensities over a valid/ready byte stream, then emits
// N_STEPS rate-coded spike vectors. Channel i spikes when its intensity is
// >= the shared 8-bit LFSR rotated left by i bits, so the firing probability
// is roughly intensity/255.
module snn_rate_encoder #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned N_STEPS = 16,
  parameter logic [7:0]  SEED    = 8'hA5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic [7:0]      pix_data,
  input  logic            pix_valid,
  output logic            pix_ready,
  output logic [N_CH-1:0] spk_out,
  output logic            spk_valid,
  input  logic            spk_ready,
  output logic            spk_last,
  output logic            busy
);

  localparam int unsigned     CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CH_W-1:0] CH_LAST   = CH_W'(N_CH - 1);
  localparam logic [7:0]      STEP_LAST = 8'(N_STEPS - 1);

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CH_W-1:0] r_ch_cnt;
  logic [7:0]      r_step_cnt;
  logic [7:0]      r_lfsr;
  logic [7:0]      r_intensity [N_CH];

  logic            w_pix_fire;
  logic            w_spk_fire;
  logic            w_last_pix;
  logic            w_last_step;
  logic [7:0]      w_lfsr_next;
  logic [15:0]     w_lfsr_dbl;

  // Handshakes are qualified by the ena-gated ready/valid, so ena=0 freezes
  // every register below without further gating.
  assign w_pix_fire  = pix_valid && pix_ready;
  assign w_spk_fire  = spk_valid && spk_ready;
  assign w_last_pix  = (r_ch_cnt == CH_LAST);
  assign w_last_step = (r_step_cnt == STEP_LAST);

  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1; never reaches zero from a non-zero seed.
  assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  // Doubled copy makes a left-rotate a plain part-select.
  assign w_lfsr_dbl  = {r_lfsr, r_lfsr};

  assign spk_last = spk_valid && w_last_step;

  // State register: LOAD after reset, otherwise follow next-state logic.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_LOAD;
    end else if (ena) begin
      r_state <= w_state_next;
    end
  end

  // Next state: LOAD->RUN on the last pixel accept, RUN->LOAD on the last beat.
  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_LOAD:  if (w_pix_fire && w_last_pix)  w_state_next = S_RUN;
      S_RUN:   if (w_spk_fire && w_last_step) w_state_next = S_LOAD;
      default: w_state_next = S_LOAD;
    endcase
  end

  // Outputs decoded from state; ready/valid are forced low while ena=0.
  always_comb begin
    pix_ready = 1'b0;
    spk_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_LOAD: pix_ready = ena;
      S_RUN: begin
        spk_valid = ena;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Spike vector: intensity compared against the per-channel rotated LFSR.
  always_comb begin
    spk_out = '0;
    for (int i = 0; i < N_CH; i++) begin
      spk_out[i] = (r_intensity[i] >= w_lfsr_dbl[15-i -: 8]);
    end
  end

  // Datapath: pixel capture, channel/step counters and LFSR stepping.
  // NOTE: the intensity registers are a handful of flops, not a RAM, so they
  // are cleared on reset to discard any partially loaded frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ch_cnt   <= '0;
      r_step_cnt <= '0;
      r_lfsr     <= SEED;
      for (int i = 0; i < N_CH; i++) begin
        r_intensity[i] <= '0;
      end
    end else begin
      if (w_pix_fire) begin
        r_intensity[r_ch_cnt] <= pix_data;
        if (w_last_pix) begin
          // Frame complete: every frame restarts from the same LFSR state.
          r_ch_cnt   <= '0;
          r_step_cnt <= '0;
          r_lfsr     <= SEED;
        end else begin
          r_ch_cnt <= r_ch_cnt + 1'b1;
        end
      end
      if (w_spk_fire) begin
        r_lfsr     <= w_lfsr_next;
        r_step_cnt <= w_last_step ? 8'd0 : r_step_cnt + 1'b1;
      end
    end
  end

endmodule
